// File: rtl/mips_pkg.sv
// Shared sizing for the CPU data-side blocks: store buffer depth, address and word widths.
// The count width helper lets each instance size its own count from its DEPTH.
package mips_pkg;
  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int WORD_W   = 32;

  // Count must reach DEPTH itself, hence one bit wider than a pointer.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int SB_CW = cnt_w(SB_DEPTH);
endpackage

// File: rtl/sbuf_fwd.sv
// Youngest-match search over the store buffer entries, walked oldest to youngest from the read pointer.
// A later match overwrites an earlier one, so the result is always the most recent store to the word.
module sbuf_fwd import mips_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int WAW   = SB_AW - 2,
  parameter int DW    = WORD_W
) (
  input  logic [DEPTH-1:0][WAW-1:0]   i_addr,
  input  logic [DEPTH-1:0][DW-1:0]    i_data,
  input  logic [DEPTH-1:0]            i_vld,
  input  logic [$clog2(DEPTH)-1:0]    i_rd_ptr,
  input  logic [WAW-1:0]              i_key,
  output logic                        o_hit,
  output logic [DW-1:0]               o_data
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] w_idx;

  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = i_rd_ptr + PW'(k);
      if (i_vld[w_idx] && (i_addr[w_idx] == i_key)) begin
        o_hit  = 1'b1;
        o_data = i_data[w_idx];
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// In-order store buffer between the CPU and data memory: drains one store per idle cycle,
// yields the memory port to loads, and forwards buffered data to matching loads.
module store_buffer import mips_pkg::*; #(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              st_req,
  input  logic [AW-1:0]     st_addr,
  input  logic [WORD_W-1:0] st_data,
  input  logic              ld_req,
  input  logic [AW-1:0]     ld_addr,
  output logic [WORD_W-1:0] ld_data,
  output logic              st_stall,
  output logic              mem_w_en,
  output logic [AW-1:0]     mem_address,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              empty,
  output logic              full
);
  localparam int CW  = cnt_w(DEPTH);
  localparam int PW  = CW - 1;
  localparam int WAW = AW - 2;

  logic [DEPTH-1:0][WAW-1:0]    r_addr;
  logic [DEPTH-1:0][WORD_W-1:0] r_data;
  logic [PW-1:0]                r_rd_ptr;
  logic [PW-1:0]                r_wr_ptr;
  logic [CW-1:0]                r_cnt;

  logic              w_drain;
  logic              w_accept;
  logic [DEPTH-1:0]  w_vld;
  logic              w_hit;
  logic [WORD_W-1:0] w_fwd_data;
  logic              w_unused;

  assign w_unused = ^st_addr[1:0];

  assign empty    = (r_cnt == '0);
  assign full     = (r_cnt == CW'(DEPTH));
  assign w_drain  = !empty && !ld_req;
  // When full, the drain frees the slot the new store lands in on the same edge.
  assign w_accept = st_req && (!full || w_drain);
  assign st_stall = st_req && full && ld_req;

  assign mem_w_en    = w_drain;
  assign mem_address = ld_req  ? ld_addr :
                       w_drain ? {r_addr[r_rd_ptr], 2'b00} : '0;
  assign mem_wdata   = w_drain ? r_data[r_rd_ptr] : '0;

  always_comb begin
    w_vld = '0;
    for (int i = 0; i < DEPTH; i++)
      w_vld[i] = {1'b0, PW'(i) - r_rd_ptr} < r_cnt;
  end

  sbuf_fwd #(.DEPTH(DEPTH), .WAW(WAW), .DW(WORD_W)) u_fwd (
    .i_addr   (r_addr),
    .i_data   (r_data),
    .i_vld    (w_vld),
    .i_rd_ptr (r_rd_ptr),
    .i_key    (ld_addr[AW-1:2]),
    .o_hit    (w_hit),
    .o_data   (w_fwd_data)
  );

  assign ld_data = (ld_req && w_hit) ? w_fwd_data : mem_rdata;

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr[r_wr_ptr] <= st_addr[AW-1:2];
      r_data[r_wr_ptr] <= st_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_drain)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_accept, w_drain})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule
